// File: rtl/gen_scheduler.sv
// gen_scheduler
//
// Frame/generation sequencer for the Game of Life core. It starts the renderer
// on every frame and launches the cell updater every GEN_DIV frames. While
// paused, a single-step request launches one update instead. The ping-pong
// board buffer select flips only at a frame boundary after the updater has
// finished. The block also arbitrates the shared board-memory read port, and
// the renderer always has priority there.
//
// Ports
//   clk_in            system clock
//   rst_in            synchronous active-high reset
//   frame_start_in    one-cycle pulse at the start of vertical blanking
//   pause_in          level, holds generation advance
//   step_in           one-cycle pulse, requests one generation while paused
//   render_done_in    renderer finished its frame
//   update_done_in    updater finished writing the next board
//   render_req_in / render_addr_in   renderer read request and address
//   update_req_in / update_addr_in   updater read request and address
//   render_start_out  one-cycle start pulse to the renderer
//   update_start_out  one-cycle start pulse to the updater
//   buf_sel_out       displayed buffer; the updater writes the other one
//   addr_r_out        board BRAM read address
//   render_gnt_out / update_gnt_out  read grants
//   gen_count_out     generations displayed since reset
//   overrun_out       sticky; a frame started while the renderer was busy
module gen_scheduler #(
   parameter int LOG_MAX_ADDR = 16,
   parameter int GEN_DIV      = 4
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    frame_start_in,
   input  logic                    pause_in,
   input  logic                    step_in,
   input  logic                    render_done_in,
   input  logic                    update_done_in,
   input  logic                    render_req_in,
   input  logic [LOG_MAX_ADDR-1:0] render_addr_in,
   input  logic                    update_req_in,
   input  logic [LOG_MAX_ADDR-1:0] update_addr_in,
   output logic                    render_start_out,
   output logic                    update_start_out,
   output logic                    buf_sel_out,
   output logic [LOG_MAX_ADDR-1:0] addr_r_out,
   output logic                    render_gnt_out,
   output logic                    update_gnt_out,
   output logic [15:0]             gen_count_out,
   output logic                    overrun_out
);

   typedef enum logic {R_IDLE, R_BUSY} r_state_t;
   typedef enum logic [1:0] {U_IDLE, U_BUSY, U_READY} u_state_t;

   localparam logic [7:0] CNT_LAST = 8'(GEN_DIV - 1);

   r_state_t    r_state_reg, r_state_next;
   u_state_t    u_state_reg, u_state_next;
   logic [7:0]  frame_cnt_reg, frame_cnt_next;
   logic        step_pend_reg, step_pend_next;
   logic        render_start_reg, render_start_next;
   logic        update_start_reg, update_start_next;
   logic        buf_sel_reg, buf_sel_next;
   logic [15:0] gen_count_reg, gen_count_next;
   logic        overrun_reg, overrun_next;
   logic        launch;

   // State register: both FSMs plus the registered outputs, so start pulses,
   // the buffer flip and the generation count all appear one cycle after
   // the frame pulse.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state_reg      <= R_IDLE;
         u_state_reg      <= U_IDLE;
         frame_cnt_reg    <= '0;
         step_pend_reg    <= 1'b0;
         render_start_reg <= 1'b0;
         update_start_reg <= 1'b0;
         buf_sel_reg      <= 1'b0;
         gen_count_reg    <= '0;
         overrun_reg      <= 1'b0;
      end else begin
         r_state_reg      <= r_state_next;
         u_state_reg      <= u_state_next;
         frame_cnt_reg    <= frame_cnt_next;
         step_pend_reg    <= step_pend_next;
         render_start_reg <= render_start_next;
         update_start_reg <= update_start_next;
         buf_sel_reg      <= buf_sel_next;
         gen_count_reg    <= gen_count_next;
         overrun_reg      <= overrun_next;
      end
   end

   // An update launches on a frame pulse when the free-running divider
   // expires or a single-step is pending.
   assign launch = (u_state_reg == U_IDLE) && frame_start_in &&
                   ((!pause_in && (frame_cnt_reg == CNT_LAST)) || step_pend_reg);

   // Next-state logic for both FSMs.
   always_comb begin
      r_state_next = r_state_reg;
      u_state_next = u_state_reg;
      case (r_state_reg)
         R_IDLE: if (frame_start_in) r_state_next = R_BUSY;
         // A done pulse wins over a coincident frame pulse.
         R_BUSY: if (render_done_in) r_state_next = R_IDLE;
         default: r_state_next = R_IDLE;
      endcase
      case (u_state_reg)
         U_IDLE:  if (launch) u_state_next = U_BUSY;
         U_BUSY:  if (update_done_in) u_state_next = U_READY;
         U_READY: if (frame_start_in) u_state_next = U_IDLE;
         default: u_state_next = U_IDLE;
      endcase
   end

   // Output/datapath logic feeding the registered outputs.
   always_comb begin
      render_start_next = (r_state_reg == R_IDLE) && frame_start_in;
      overrun_next      = overrun_reg ||
                          ((r_state_reg == R_BUSY) && frame_start_in && !render_done_in);
      update_start_next = launch;

      frame_cnt_next = frame_cnt_reg;
      if (frame_start_in && (u_state_reg == U_IDLE) && !pause_in)
         frame_cnt_next = (frame_cnt_reg == CNT_LAST) ? 8'd0 : frame_cnt_reg + 8'd1;

      step_pend_next = step_pend_reg;
      if (launch)
         step_pend_next = 1'b0;
      else if (step_in && pause_in)
         step_pend_next = 1'b1;

      buf_sel_next   = buf_sel_reg;
      gen_count_next = gen_count_reg;
      if ((u_state_reg == U_READY) && frame_start_in) begin
         buf_sel_next   = !buf_sel_reg;
         gen_count_next = gen_count_reg + 16'd1;
      end
   end

   assign render_start_out = render_start_reg;
   assign update_start_out = update_start_reg;
   assign buf_sel_out      = buf_sel_reg;
   assign gen_count_out    = gen_count_reg;
   assign overrun_out      = overrun_reg;

   // Read-port arbitration: the renderer has a pixel deadline, so it always
   // wins; the updater stalls while it is not granted.
   assign render_gnt_out = render_req_in;
   assign update_gnt_out = update_req_in && !render_req_in;
   assign addr_r_out     = render_req_in ? render_addr_in : update_addr_in;

endmodule

// File: doc/gen_scheduler.md
# gen_scheduler

Frame/generation sequencer for the Game of Life core. It starts the renderer on every frame and launches the cell updater every GEN_DIV frames, or on a single-step when paused. It flips the ping-pong board buffer select only at frame boundaries, and arbitrates the shared board-memory read port between renderer and updater. It sits between the VGA timing source, `renderer`, the updater, and the board BRAM read port.

## Interface
- `LOG_MAX_ADDR`, default 16: board memory address width (matches `common.svh`).
- `GEN_DIV`, default 4: frames per generation when free-running; legal range 1..255.
- `clk_in` input 1: system clock; the only clock.
- `rst_in` input 1: synchronous, active-high reset.
- `frame_start_in` input 1: one-cycle pulse at the start of vertical blanking.
- `pause_in` input 1: level; holds generation advance.
- `step_in` input 1: one-cycle pulse; requests one generation while paused.
- `render_done_in` input 1: pulse from renderer, frame finished.
- `update_done_in` input 1: pulse from updater, next board fully written.
- `render_req_in` input 1: renderer read request.
- `render_addr_in` input LOG_MAX_ADDR: renderer read address.
- `update_req_in` input 1: updater read request.
- `update_addr_in` input LOG_MAX_ADDR: updater read address.
- `render_start_out` output 1: one-cycle start pulse to renderer.
- `update_start_out` output 1: one-cycle start pulse to updater.
- `buf_sel_out` output 1: current (displayed) buffer; the updater writes `!buf_sel_out`.
- `addr_r_out` output LOG_MAX_ADDR: board BRAM read address.
- `render_gnt_out`, `update_gnt_out` output 1 each: read grants.
- `gen_count_out` output 16: generations displayed since reset.
- `overrun_out` output 1: sticky; a frame started while the renderer was still busy.

## Operation
- Render FSM, states R_IDLE and R_BUSY.
  - R_IDLE + `frame_start_in`: pulse `render_start_out`, go to R_BUSY.
  - R_BUSY + `render_done_in`: go to R_IDLE.
  - R_BUSY + `frame_start_in`: set `overrun_out`, no restart, stay in R_BUSY.
  - `render_done_in` in R_IDLE is ignored.
- Frame counter `frame_cnt`, 8 bits.
  - Increments mod GEN_DIV on every `frame_start_in` while the update FSM is in U_IDLE and `pause_in`=0.
  - Holds in all other cases.
- Step latch.
  - `step_in` with `pause_in`=1 sets `step_pend`.
  - `step_in` with `pause_in`=0 is ignored.
  - `step_pend` is cleared when an update launches.
- Update FSM, states U_IDLE, U_BUSY and U_READY.
  - U_IDLE + `frame_start_in` + ((`pause_in`=0 and `frame_cnt`==GEN_DIV-1) or `step_pend`): pulse `update_start_out`, go to U_BUSY.
  - U_BUSY + `update_done_in`: go to U_READY.
  - U_READY + `frame_start_in`: toggle `buf_sel_out`, increment `gen_count_out` (wraps at 0xFFFF→0), go to U_IDLE.
  - The swap happens regardless of `pause_in`. No new update launches on the swap frame.
  - `update_done_in` outside U_BUSY is ignored.
- Arbitration (combinational):
  - `render_gnt_out` = `render_req_in`.
  - `update_gnt_out` = `update_req_in` & !`render_req_in`.
  - `addr_r_out` = `render_addr_in` when `render_req_in`, else `update_addr_in`.
  - Renderer has fixed priority because pixel deadline. The updater stalls while not granted.

## Timing
- Reset: all outputs 0, both FSMs idle, `frame_cnt`=0, `step_pend`=0. Reset mid-update abandons the update; `buf_sel_out` returns to 0.
- `frame_start_in` at cycle T:
  - `render_start_out` and `update_start_out` are high during T+1 only.
  - `buf_sel_out` and `gen_count_out` change at the T+1 edge.
  - The renderer therefore always starts on the new buffer in a swap frame.
- Done pulse at cycle T: state changes at T+1. A done pulse coincident with `frame_start_in` in R_BUSY counts as done; no overrun, no start that frame.
- Grants and `addr_r_out` have zero added latency; BRAM read latency is seen unchanged by requesters.
- Reset has priority over every other input.

## Test plan
- Reset, GEN_DIV=4, 8 frame pulses, renderer done between pulses → 8 `render_start_out` pulses; `update_start_out` on frame pulse 4; `overrun_out`=0.
- Updater done before frame pulse 5 → `buf_sel_out` 0→1 and `gen_count_out`=1 at frame 5 + 1 cycle; next update launches on frame 9.
- `pause_in`=1 for 10 frames → no `update_start_out`. One `step_in` → exactly one update at the next frame pulse, swap at the frame after done, `gen_count_out` +1.
- Renderer withholds done across a frame pulse → `overrun_out`=1 and sticky; no second `render_start_out` until done.
- `render_req_in` and `update_req_in` both high with addresses 0x0010/0x0200 → `addr_r_out`=0x0010, only `render_gnt_out`; drop render request → 0x0200, `update_gnt_out`=1 same cycle.
- Assert `rst_in` while in U_BUSY with `buf_sel_out`=1 → next cycle all outputs 0; a late `update_done_in` is ignored.
